// File: rtl/router_fsm.sv
// Control FSM of the 1x3 packet router: header decode, load sequencing, full stall.
// Define ROUTER_FSM_SOFT_RESET_EN to compile in the per-port soft-reset abort.
module router_fsm (
  input  logic       clk,
  input  logic       resetn,
  input  logic       packet_valid,
  input  logic [1:0] datain,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       parity_done,
  input  logic       low_packet_valid,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       write_enb_reg,
  output logic       rst_int_reg,
  output logic       busy
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS,
    LOAD_FIRST_DATA,
    LOAD_DATA,
    FIFO_FULL_STATE,
    LOAD_AFTER_FULL,
    LOAD_PARITY,
    CHECK_PARITY_ERROR,
    WAIT_TILL_EMPTY
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] addr_q, addr_d;
  logic [1:0] sel;
  logic       empty_sel;
  logic       soft_sel;

  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q <= DECODE_ADDRESS;
      addr_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    addr_d = addr_q;
    if (state_q == DECODE_ADDRESS && packet_valid)
      addr_d = datain;
  end

  // While decoding, the header byte itself picks the FIFO to test.
  always_comb begin
    sel = (state_q == DECODE_ADDRESS) ? datain : addr_q;
    case (sel)
      2'd0:    empty_sel = fifo_empty_0;
      2'd1:    empty_sel = fifo_empty_1;
      2'd2:    empty_sel = fifo_empty_2;
      default: empty_sel = 1'b0;
    endcase
  end

`ifdef ROUTER_FSM_SOFT_RESET_EN
  always_comb begin
    case (addr_q)
      2'd0:    soft_sel = soft_reset_0;
      2'd1:    soft_sel = soft_reset_1;
      2'd2:    soft_sel = soft_reset_2;
      default: soft_sel = 1'b0;
    endcase
  end
`else
  logic unused_soft;
  assign unused_soft = soft_reset_0 ^ soft_reset_1 ^ soft_reset_2;
  assign soft_sel    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    if (soft_sel && state_q != DECODE_ADDRESS) begin
      state_d = DECODE_ADDRESS;
    end else begin
      case (state_q)
        DECODE_ADDRESS: begin
          if (packet_valid && datain != 2'd3)
            state_d = empty_sel ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        end
        LOAD_FIRST_DATA:
          state_d = LOAD_DATA;
        LOAD_DATA: begin
          if (fifo_full)
            state_d = FIFO_FULL_STATE;
          else if (!packet_valid)
            state_d = LOAD_PARITY;
        end
        FIFO_FULL_STATE: begin
          if (!fifo_full)
            state_d = LOAD_AFTER_FULL;
        end
        LOAD_AFTER_FULL: begin
          if (parity_done)
            state_d = DECODE_ADDRESS;
          else if (low_packet_valid)
            state_d = LOAD_PARITY;
          else
            state_d = LOAD_DATA;
        end
        LOAD_PARITY:
          state_d = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR:
          state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
        WAIT_TILL_EMPTY: begin
          if (empty_sel)
            state_d = LOAD_FIRST_DATA;
        end
        default:
          state_d = DECODE_ADDRESS;
      endcase
    end
  end

  always_comb begin
    detect_add    = (state_q == DECODE_ADDRESS);
    lfd_state     = (state_q == LOAD_FIRST_DATA);
    ld_state      = (state_q == LOAD_DATA);
    laf_state     = (state_q == LOAD_AFTER_FULL);
    full_state    = (state_q == FIFO_FULL_STATE);
    write_enb_reg = (state_q == LOAD_DATA)
                 || (state_q == LOAD_PARITY)
                 || (state_q == LOAD_AFTER_FULL);
    rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
    busy          = (state_q != DECODE_ADDRESS)
                 && (state_q != LOAD_DATA);
  end

endmodule

// File: tb/tb_router_fsm.sv
// Scoreboard bench for router_fsm: stimulus queues expected output vectors,
// a monitor pops and compares one vector after each rising edge.
module tb_router_fsm;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic       packet_valid = 1'b0;
  logic [1:0] datain = 2'd0;
  logic       fifo_full = 1'b0;
  logic       fifo_empty_0 = 1'b0;
  logic       fifo_empty_1 = 1'b0;
  logic       fifo_empty_2 = 1'b0;
  logic       soft_reset_0 = 1'b0;
  logic       soft_reset_1 = 1'b0;
  logic       soft_reset_2 = 1'b0;
  logic       parity_done = 1'b0;
  logic       low_packet_valid = 1'b0;
  logic       detect_add, lfd_state, ld_state, laf_state;
  logic       full_state, write_enb_reg, rst_int_reg, busy;

  // {detect_add,lfd,ld,laf,full,write_enb,rst_int,busy}
  localparam logic [7:0] DA  = 8'b1000_0000;
  localparam logic [7:0] LFD = 8'b0100_0001;
  localparam logic [7:0] LD  = 8'b0010_0100;
  localparam logic [7:0] LAF = 8'b0001_0101;
  localparam logic [7:0] FFS = 8'b0000_1001;
  localparam logic [7:0] LP  = 8'b0000_0101;
  localparam logic [7:0] CPE = 8'b0000_0011;
  localparam logic [7:0] WTE = 8'b0000_0001;

  typedef struct {
    logic [7:0] exp;
    string      name;
  } item_t;

  item_t sb[$];
  int    vectors = 0;
  int    miscompares = 0;

  router_fsm dut (
    .clk              (clk),
    .resetn           (resetn),
    .packet_valid     (packet_valid),
    .datain           (datain),
    .fifo_full        (fifo_full),
    .fifo_empty_0     (fifo_empty_0),
    .fifo_empty_1     (fifo_empty_1),
    .fifo_empty_2     (fifo_empty_2),
    .soft_reset_0     (soft_reset_0),
    .soft_reset_1     (soft_reset_1),
    .soft_reset_2     (soft_reset_2),
    .parity_done      (parity_done),
    .low_packet_valid (low_packet_valid),
    .detect_add       (detect_add),
    .lfd_state        (lfd_state),
    .ld_state         (ld_state),
    .laf_state        (laf_state),
    .full_state       (full_state),
    .write_enb_reg    (write_enb_reg),
    .rst_int_reg      (rst_int_reg),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  // Monitor: every cycle the DUT presents a new Moore output vector.
  initial begin
    item_t      it;
    logic [7:0] act;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        it  = sb.pop_front();
        act = {detect_add, lfd_state, ld_state, laf_state,
               full_state, write_enb_reg, rst_int_reg, busy};
        vectors++;
        if (act !== it.exp) begin
          miscompares++;
          $display("FAIL %s: got %b expected %b", it.name, act, it.exp);
        end
      end
    end
  end

  task automatic step(input string nm, input logic rst,
                      input logic pv, input logic [1:0] din,
                      input logic ff, input logic [2:0] emp,
                      input logic [2:0] sr, input logic pd,
                      input logic lpv, input logic [7:0] exp);
    item_t it;
    @(negedge clk);
    resetn           = rst;
    packet_valid     = pv;
    datain           = din;
    fifo_full        = ff;
    {fifo_empty_2, fifo_empty_1, fifo_empty_0} = emp;
    {soft_reset_2, soft_reset_1, soft_reset_0} = sr;
    parity_done      = pd;
    low_packet_valid = lpv;
    it.exp  = exp;
    it.name = nm;
    sb.push_back(it);
  endtask

  initial begin
    int budget;
    //     name         rst pv din   ff  emp     sr      pd lpv exp
    step("reset",       1, 0, 2'd0, 0, 3'b000, 3'b000, 0, 0, DA);
    step("idle",        0, 0, 2'd0, 0, 3'b000, 3'b000, 0, 0, DA);
    // address 1, short packet
    step("a1_lfd",      0, 1, 2'd1, 0, 3'b010, 3'b000, 0, 0, LFD);
    step("a1_ld",       0, 1, 2'd2, 0, 3'b010, 3'b000, 0, 0, LD);
    step("a1_ld_hold",  0, 1, 2'd3, 0, 3'b010, 3'b000, 0, 0, LD);
    step("a1_lp",       0, 0, 2'd0, 0, 3'b010, 3'b000, 0, 0, LP);
    step("a1_cpe",      0, 0, 2'd0, 0, 3'b010, 3'b000, 0, 0, CPE);
    step("a1_da",       0, 0, 2'd0, 0, 3'b010, 3'b000, 0, 0, DA);
    // full with pv low in LOAD_DATA: full wins, then low_packet_valid
    step("f1_lfd",      0, 1, 2'd1, 0, 3'b010, 3'b000, 0, 0, LFD);
    step("f1_ld",       0, 1, 2'd1, 0, 3'b010, 3'b000, 0, 0, LD);
    step("f1_full_win", 0, 0, 2'd1, 1, 3'b010, 3'b000, 0, 0, FFS);
    step("f1_ffs_hold", 0, 0, 2'd1, 1, 3'b010, 3'b000, 0, 0, FFS);
    step("f1_laf",      0, 0, 2'd1, 0, 3'b010, 3'b000, 0, 0, LAF);
    step("f1_lpv_lp",   0, 0, 2'd1, 0, 3'b010, 3'b000, 0, 1, LP);
    step("f1_cpe",      0, 0, 2'd1, 0, 3'b010, 3'b000, 0, 0, CPE);
    step("f1_da",       0, 0, 2'd1, 0, 3'b010, 3'b000, 0, 0, DA);
    // LOAD_AFTER_FULL back to LOAD_DATA
    step("f2_lfd",      0, 1, 2'd1, 0, 3'b010, 3'b000, 0, 0, LFD);
    step("f2_ld",       0, 1, 2'd1, 0, 3'b010, 3'b000, 0, 0, LD);
    step("f2_ffs",      0, 1, 2'd1, 1, 3'b010, 3'b000, 0, 0, FFS);
    step("f2_laf",      0, 1, 2'd1, 0, 3'b010, 3'b000, 0, 0, LAF);
    step("f2_laf_ld",   0, 1, 2'd1, 0, 3'b010, 3'b000, 0, 0, LD);
    step("f2_lp",       0, 0, 2'd1, 0, 3'b010, 3'b000, 0, 0, LP);
    step("f2_cpe",      0, 0, 2'd1, 0, 3'b010, 3'b000, 0, 0, CPE);
    step("f2_da",       0, 0, 2'd1, 0, 3'b010, 3'b000, 0, 0, DA);
    // full in CHECK_PARITY_ERROR, exit via parity_done
    step("c_lfd",       0, 1, 2'd0, 0, 3'b001, 3'b000, 0, 0, LFD);
    step("c_ld",        0, 1, 2'd0, 0, 3'b001, 3'b000, 0, 0, LD);
    step("c_lp",        0, 0, 2'd0, 0, 3'b001, 3'b000, 0, 0, LP);
    step("c_cpe",       0, 0, 2'd0, 0, 3'b001, 3'b000, 0, 0, CPE);
    step("c_cpe_ffs",   0, 0, 2'd0, 1, 3'b001, 3'b000, 0, 0, FFS);
    step("c_laf",       0, 0, 2'd0, 0, 3'b001, 3'b000, 0, 0, LAF);
    step("c_pd_da",     0, 0, 2'd0, 0, 3'b001, 3'b000, 1, 1, DA);
    // invalid address 3 and idle pv low
    step("a3_stay",     0, 1, 2'd3, 0, 3'b111, 3'b000, 0, 0, DA);
    step("nopv_stay",   0, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0, DA);
    // address 2 not empty: wait on the latched address, then reset abort
    step("w_wte",       0, 1, 2'd2, 0, 3'b011, 3'b000, 0, 0, WTE);
    step("w_hold_addr", 0, 1, 2'd0, 0, 3'b011, 3'b000, 0, 0, WTE);
    step("w_other_sr",  0, 1, 2'd0, 0, 3'b011, 3'b011, 0, 0, WTE);
    step("w_lfd",       0, 1, 2'd0, 0, 3'b100, 3'b000, 0, 0, LFD);
    step("w_ld",        0, 1, 2'd0, 0, 3'b100, 3'b000, 0, 0, LD);
    step("w_rst_abort", 1, 1, 2'd0, 0, 3'b100, 3'b000, 0, 0, DA);
    // address 2 wait, soft reset on port 2
    step("s_wte",       0, 1, 2'd2, 0, 3'b000, 3'b000, 0, 0, WTE);
`ifdef ROUTER_FSM_SOFT_RESET_EN
    step("s_soft_abort",0, 0, 2'd2, 0, 3'b000, 3'b100, 0, 0, DA);
`else
    step("s_soft_ign",  0, 0, 2'd2, 0, 3'b000, 3'b100, 0, 0, WTE);
`endif
    step("s_rst_soft",  1, 0, 2'd2, 0, 3'b000, 3'b100, 0, 0, DA);
    step("s_idle",      0, 0, 2'd0, 0, 3'b000, 3'b000, 0, 0, DA);

    budget = 0;
    while (sb.size() > 0 && budget < 10) begin
      @(negedge clk);
      budget++;
    end
    if (sb.size() > 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
